dmem_arb: RTL

- Single-port data-memory arbiter between the processor core's load/store path and a second requester, the host/DMA port.
- Sits between the core's `lp`/`bo`/`dmwe` data-memory signals and the `dmem` instance.
- Core gets fixed priority, with starvation protection for the host.
- Stalls the core (holds the PC) whenever the core loses arbitration.

---
 rtl/dmem_arb_if.sv | 43 ++++
 rtl/dmem_arb.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arb: core load/store port, host/DMA port and data-memory port.
// The slave modport is the arbiter's view; master is the surrounding core/host/memory side.
interface dmem_arb_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd;
  logic [DW-1:0] c_rd;
  logic          c_stall;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wd;
  logic [DW-1:0] h_rd;
  logic          h_ack;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic          m_we;
  logic [DW-1:0] m_rd;

  modport slave (
    input  c_req, c_we, c_addr, c_wd,
    output c_rd, c_stall,
    input  h_req, h_we, h_addr, h_wd,
    output h_rd, h_ack,
    output m_addr, m_wd, m_we,
    input  m_rd
  );

  modport master (
    output c_req, c_we, c_addr, c_wd,
    input  c_rd, c_stall,
    output h_req, h_we, h_addr, h_wd,
    input  h_rd, h_ack,
    input  m_addr, m_wd, m_we,
    output m_rd
  );
endinterface

// File: rtl/dmem_arb.sv
// Single-port data-memory arbiter: core has fixed priority, host is protected from starvation.
// Define DMARB_RR_EN to resolve contention round-robin instead of by the starvation counter.
module dmem_arb #(
  parameter int DW         = 16,
  parameter int AW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic     clk,
  input  logic     rst,
  dmem_arb_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HACK = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic          gnt_h;
  logic          gnt_c;
  logic          host_wins;
  logic          h_ack_q;
  logic [DW-1:0] h_rd_q;

`ifdef DMARB_RR_EN
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  logic last_owner;

  // Under contention the requester that did not own memory last time wins.
  assign host_wins = (last_owner == OWNER_CORE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWNER_HOST;
    end else if (gnt_h) begin
      last_owner <= OWNER_HOST;
    end else if (gnt_c) begin
      last_owner <= OWNER_CORE;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       contend;

  assign contend   = bus.h_req & bus.c_req;
  assign host_wins = (starve_cnt == STARVE_LIM);

  // Counts consecutive contention cycles the host lost; frozen while the host is being acked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (gnt_h || !bus.h_req) begin
        starve_cnt <= '0;
      end else if (contend && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  // The host can only be granted from IDLE; the ack cycle always belongs to the core.
  always_comb begin
    gnt_h = 1'b0;
    gnt_c = bus.c_req;
    if (state == IDLE) begin
      gnt_h = bus.h_req & (~bus.c_req | host_wins);
      gnt_c = bus.c_req & ~gnt_h;
    end
  end

  always_comb begin
    if (gnt_h) begin
      bus.m_addr = bus.h_addr;
      bus.m_wd   = bus.h_wd;
      bus.m_we   = bus.h_we;
    end else begin
      bus.m_addr = bus.c_addr;
      bus.m_wd   = bus.c_wd;
      bus.m_we   = bus.c_we & gnt_c;
    end
  end

  assign bus.c_rd    = bus.m_rd;
  assign bus.c_stall = bus.c_req & ~gnt_c;
  assign bus.h_ack   = h_ack_q;
  assign bus.h_rd    = h_rd_q;

  always_comb begin
    state_nx = IDLE;
    if ((state == IDLE) && gnt_h) begin
      state_nx = HACK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Read data is captured for host writes too, so h_rd always reflects the last host access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_ack_q <= 1'b0;
      h_rd_q  <= '0;
    end else begin
      h_ack_q <= gnt_h;
      if (gnt_h) begin
        h_rd_q <= bus.m_rd;
      end
    end
  end

endmodule
